reg_read_port: RTL and testbench

- 16-entry register file with one one-hot write port and two registered read ports.
- Write side is driven by the register write decoder's one-hot Wordline plus write data.
- Read side returns two operands one cycle after a read request, with optional same-cycle write bypass.
- Sits between the write decoder and the ALU operand inputs in the datapath.

---
 rtl/reg_read_port_if.sv | 25 ++
 rtl/reg_read_port.sv | 86 ++++++++
 tb/tb_reg_read_port.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/reg_read_port_if.sv
// Bus bundle for the register file: one-hot write side plus two-operand read side.
// master drives requests and write data, slave is the register file itself.
interface reg_read_port_if #(
    parameter int WIDTH = 16
);
    logic [15:0]      Wordline;
    logic [WIDTH-1:0] writeData;
    logic [3:0]       regIdA;
    logic [3:0]       regIdB;
    logic             readReq;
    logic [WIDTH-1:0] readDataA;
    logic [WIDTH-1:0] readDataB;
    logic             readValid;
    logic             writeErr;

    modport master (
        output Wordline, writeData, regIdA, regIdB, readReq,
        input  readDataA, readDataB, readValid, writeErr
    );

    modport slave (
        input  Wordline, writeData, regIdA, regIdB, readReq,
        output readDataA, readDataB, readValid, writeErr
    );
endinterface

// File: rtl/reg_read_port.sv
// 16-entry register file: one-hot write port, two registered read ports with
// optional same-edge write bypass and a sticky multi-hot write error flag.
module reg_read_port #(
    parameter int WIDTH  = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    reg_read_port_if.slave rf
);
    localparam int NREGS = 16;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [WIDTH-1:0] read_data_a_q, read_data_a_d;
    logic [WIDTH-1:0] read_data_b_q, read_data_b_d;
    logic             read_valid_q, read_valid_d;
    logic             write_err_q, write_err_d;

    logic             wl_any;
    logic             wl_onehot;
    logic             wl_multi;
    logic [WIDTH-1:0] port_a_val;
    logic [WIDTH-1:0] port_b_val;

    // Clearing the lowest set bit leaves zero only when exactly one bit was set.
    assign wl_any    = |rf.Wordline;
    assign wl_onehot = wl_any && ((rf.Wordline & (rf.Wordline - 16'd1)) == 16'd0);
    assign wl_multi  = wl_any && !wl_onehot;

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wl_onehot && rf.Wordline[i]) begin
                regs_d[i] = rf.writeData;
            end
        end
    end

    // Read operands come from the pre-write contents unless bypass forwards the
    // data being written on this same edge.
    always_comb begin
        port_a_val = regs_q[rf.regIdA];
        port_b_val = regs_q[rf.regIdB];
        if (BYPASS && wl_onehot && rf.Wordline[rf.regIdA]) begin
            port_a_val = rf.writeData;
        end
        if (BYPASS && wl_onehot && rf.Wordline[rf.regIdB]) begin
            port_b_val = rf.writeData;
        end

        read_data_a_d = read_data_a_q;
        read_data_b_d = read_data_b_q;
        if (rf.readReq) begin
            read_data_a_d = port_a_val;
            read_data_b_d = port_b_val;
        end
        read_valid_d = rf.readReq;
        write_err_d  = write_err_q | wl_multi;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            read_data_a_q <= '0;
            read_data_b_q <= '0;
            read_valid_q  <= 1'b0;
            write_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            read_data_a_q <= read_data_a_d;
            read_data_b_q <= read_data_b_d;
            read_valid_q  <= read_valid_d;
            write_err_q   <= write_err_d;
        end
    end

    assign rf.readDataA = read_data_a_q;
    assign rf.readDataB = read_data_b_q;
    assign rf.readValid = read_valid_q;
    assign rf.writeErr  = write_err_q;
endmodule

// File: tb/tb_reg_read_port.sv
// Randomized and directed bench for reg_read_port against a behavioural register-file model.
module tb_reg_read_port;
    localparam int WIDTH  = 16;
    localparam bit BYPASS = 1'b1;

    logic clk;
    logic reset;
    reg_read_port_if #(.WIDTH(WIDTH)) bus ();

    reg_read_port #(.WIDTH(WIDTH), .BYPASS(BYPASS)) dut (
        .clk   (clk),
        .reset (reset),
        .rf    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] mem [16];
    logic [WIDTH-1:0] exp_a, exp_b;
    logic             exp_v, exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mem[i] = '0;
        exp_a = '0; exp_b = '0; exp_v = 1'b0; exp_err = 1'b0;
    endtask

    // Applies one rising edge worth of spec rules to the model.
    task automatic model_update();
        int n_set;
        int widx;
        if (reset) begin
            model_clear();
            return;
        end
        n_set = $countones(bus.Wordline);
        widx  = -1;
        for (int i = 0; i < 16; i++) if (bus.Wordline[i]) widx = i;
        exp_v = bus.readReq;
        if (bus.readReq) begin
            exp_a = (BYPASS && n_set == 1 && widx == int'(bus.regIdA)) ? bus.writeData : mem[bus.regIdA];
            exp_b = (BYPASS && n_set == 1 && widx == int'(bus.regIdB)) ? bus.writeData : mem[bus.regIdB];
        end
        if (n_set == 1) mem[widx] = bus.writeData;
        if (n_set > 1) exp_err = 1'b1;
    endtask

    task automatic compare_all();
        check("readDataA", 32'(bus.readDataA), 32'(exp_a));
        check("readDataB", 32'(bus.readDataB), 32'(exp_b));
        check("readValid", 32'(bus.readValid), 32'(exp_v));
        check("writeErr",  32'(bus.writeErr),  32'(exp_err));
        if (bus.readValid)
            $display("t=%0t read A=%h B=%h err=%0b", $time, bus.readDataA, bus.readDataB, bus.writeErr);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic drive(input logic [15:0] wl, input logic [WIDTH-1:0] wd,
                         input logic req, input logic [3:0] ia, input logic [3:0] ib);
        bus.Wordline  = wl;
        bus.writeData = wd;
        bus.readReq   = req;
        bus.regIdA    = ia;
        bus.regIdB    = ib;
    endtask

    initial begin
        logic [15:0] wl;
        int b0, b1;
        drive(16'h0, '0, 1'b0, 4'd0, 4'd0);
        reset = 1'b1;
        model_clear();
        step();
        step();
        check("reset_valid", 32'(bus.readValid), 32'd0);
        check("reset_err", 32'(bus.writeErr), 32'd0);
        reset = 1'b0;

        // First read after reset
        drive(16'h0, '0, 1'b1, 4'd3, 4'd9);
        step();
        check("first_readA", 32'(bus.readDataA), 32'h0);
        check("first_readB", 32'(bus.readDataB), 32'h0);
        check("first_valid", 32'(bus.readValid), 32'd1);
        drive(16'h0, '0, 1'b0, 4'd3, 4'd9);
        step();
        check("first_valid_drop", 32'(bus.readValid), 32'd0);

        // Write/read sweep
        for (int i = 0; i < 16; i++) begin
            drive(16'(1 << i), 16'hA000 + 16'(i), 1'b0, 4'd0, 4'd0);
            step();
        end
        for (int i = 0; i < 16; i++) begin
            drive(16'h0, '0, 1'b1, 4'(i), 4'(15 - i));
            step();
            check("sweep_A", 32'(bus.readDataA), 32'(16'hA000 + 16'(i)));
            check("sweep_B", 32'(bus.readDataB), 32'(16'hA000 + 16'(15 - i)));
            check("sweep_valid", 32'(bus.readValid), 32'd1);
        end

        // Bypass on register 5
        drive(16'h0020, 16'h1111, 1'b0, 4'd0, 4'd0);
        step();
        drive(16'h0020, 16'h2222, 1'b1, 4'd5, 4'd5);
        step();
        check("bypass_A", 32'(bus.readDataA), BYPASS ? 32'h2222 : 32'h1111);
        check("bypass_B", 32'(bus.readDataB), BYPASS ? 32'h2222 : 32'h1111);
        drive(16'h0, '0, 1'b1, 4'd5, 4'd0);
        step();
        check("bypass_after", 32'(bus.readDataA), 32'h2222);

        // Hold while reg2 is rewritten
        drive(16'h0004, 16'h00AB, 1'b0, 4'd2, 4'd2);
        step();
        drive(16'h0000, '0, 1'b1, 4'd2, 4'd2);
        step();
        check("hold_first", 32'(bus.readDataA), 32'h00AB);
        for (int i = 0; i < 3; i++) begin
            drive(16'h0004, 16'h00CD, 1'b0, 4'd2, 4'd2);
            step();
            check("hold_A", 32'(bus.readDataA), 32'h00AB);
            check("hold_valid", 32'(bus.readValid), 32'd0);
        end

        // Multi-hot write
        check("err_before_multi", 32'(bus.writeErr), 32'd0);
        drive(16'h0003, 16'hFFFF, 1'b0, 4'd0, 4'd0);
        step();
        check("multi_err", 32'(bus.writeErr), 32'd1);
        drive(16'h0000, '0, 1'b1, 4'd0, 4'd1);
        step();
        check("multi_reg0", 32'(bus.readDataA), 32'hA000);
        check("multi_reg1", 32'(bus.readDataB), 32'hA001);
        check("multi_sticky", 32'(bus.writeErr), 32'd1);

        // Reset asserted between edges during a write burst
        drive(16'h0400, 16'h5A5A, 1'b1, 4'd10, 4'd4);
        step();
        drive(16'h0800, 16'h6B6B, 1'b1, 4'd11, 4'd12);
        @(posedge clk);
        model_update();
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        check("async_rst_A", 32'(bus.readDataA), 32'h0);
        check("async_rst_B", 32'(bus.readDataB), 32'h0);
        check("async_rst_valid", 32'(bus.readValid), 32'd0);
        check("async_rst_err", 32'(bus.writeErr), 32'd0);
        @(negedge clk);
        compare_all();
        step();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive(16'h0, '0, 1'b1, 4'(i), 4'(15 - i));
            step();
            check("post_rst_A", 32'(bus.readDataA), 32'h0);
            check("post_rst_B", 32'(bus.readDataB), 32'h0);
        end

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0: wl = 16'h0;
                1: begin
                    b0 = $urandom_range(0, 15);
                    b1 = (b0 + $urandom_range(1, 15)) % 16;
                    wl = 16'(1 << b0) | 16'(1 << b1);
                end
                default: wl = 16'(1 << $urandom_range(0, 15));
            endcase
            drive(wl, 16'($urandom), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
